tlk2711_rx_checker: RTL and testbench
=====================================

# tlk2711_rx_checker

Receive-side frame decoder and pattern checker for the TLK2711 SERDES link, in the `rx_clk` domain directly downstream of the TLK2711 parallel receive pins. It acquires word sync on the idle comma (K28.5/D5.6) and detects SOF (K28.5/D11.5). It then checks each fixed-length data frame against the incrementing test pattern produced by the transmit-side frame generator and keeps frame and error statistics.

## Interface
- `FRAME_LEN`, default 32: data words per frame, range 2..256.
- `LOCK_CNT`, default 4: consecutive comma words needed to declare sync.
- `LOSS_CNT`, default 4: consecutive invalid words needed to drop sync.
- `rx_clk`  in  1  receive clock; the only clock.
- `rst`  in  1  reset; asynchronous, active-high.
- `i_rxd`  in  16  received word; [15:8] is the MSB character.
- `i_rkmsb`  in  1  K flag for `i_rxd[15:8]`.
- `i_rklsb`  in  1  K flag for `i_rxd[7:0]`.
- `i_clr_cnt`  in  1  synchronous clear of all statistics counters.
- `o_sync`  out  1  word sync acquired.
- `o_data`  out  16  frame payload word.
- `o_valid`  out  1  `o_data` is a payload word.
- `o_sof`  out  1  with `o_valid`, marks the first payload word.
- `o_eof`  out  1  with `o_valid`, marks the last payload word.
- `o_frame_err`  out  1  one-cycle pulse: frame finished with a mismatch, or frame aborted.
- `o_frame_cnt`  out  32  good frames received; wraps.
- `o_err_cnt`  out  16  mismatched payload words plus aborts; saturates at 0xFFFF.

## Operation
- Inputs are registered once on entry (`rxd_q`, `rk_q`). All decoding uses the registered copies.
- Word classes (constants K28_5=0xBC, D5_6=0xC5, D11_5=0xAB):
  - COMMA: rk=10, data 0xBCC5.
  - SOFW: rk=10, data 0xBCAB.
  - DATA: rk=00.
  - BAD: anything else.
- **State machine**, reset state HUNT:
  - HUNT:
    - COMMA increments `lock_cnt`; any other word clears it.
    - When `lock_cnt` reaches LOCK_CNT: go to SYNC, set `o_sync`=1.
  - SYNC:
    - COMMA clears `loss_cnt`.
    - SOFW: go to FRAME, `idx`=0, `bad`=0.
    - DATA or BAD increments `loss_cnt`.
    - When `loss_cnt` reaches LOSS_CNT: go to HUNT, `o_sync`=0, `lock_cnt`=0.
  - FRAME, on DATA:
    - Emit the word with `o_valid`=1.
    - `o_sof`=1 when `idx`==0; `o_eof`=1 when `idx`==FRAME_LEN-1.
    - Expected value: both bytes equal {3'b000, idx[4:0]}. A mismatch sets `bad` and increments `o_err_cnt`.
    - Increment `idx`.
    - On the last word: go to SYNC. If `bad` (including a mismatch on this word), pulse `o_frame_err`; otherwise increment `o_frame_cnt`.
  - FRAME, on a K word (abort): pulse `o_frame_err`, increment `o_err_cnt`, no EOF is emitted.
    - SOFW: restart FRAME with `idx`=0.
    - COMMA: go to SYNC.
    - BAD: go to SYNC and set `loss_cnt`=1.
- `i_clr_cnt` zeroes `o_frame_cnt` and `o_err_cnt`. If an increment occurs in the same cycle, the clear wins.
- `o_err_cnt` holds at 0xFFFF. `o_frame_cnt` wraps 0xFFFFFFFF→0.
- `o_data` holds its last value when `o_valid`=0.

## Timing
- Reset values:
  - State: HUNT.
  - All outputs 0: `o_sync`, `o_data`, `o_valid`, `o_sof`, `o_eof`, `o_frame_err`, both counters.
  - Internal `lock_cnt`, `loss_cnt`, `idx`, `bad`: 0.
- Reset may assert mid-frame. Everything returns immediately to the reset values, and the partial frame is not counted.
- Latency, pin to `o_data`/`o_valid`: 2 `rx_clk` cycles (input register, then output register).
- `o_frame_err` and counter updates appear in the same cycle as the `o_eof` word, or 2 cycles after the aborting word.
- `o_sync` rises 2 cycles after the LOCK_CNT-th consecutive comma is on the pins.
- No back-pressure; one word is accepted every cycle.

## Structure
- Package `tlk2711_pkg` holds:
  - K28_5, D5_6, D11_5 and the word-class enum.
  - The rx state enum: HUNT/SYNC/FRAME.
  - Shared with the transmit frame generator.
- One sub-module, `tlk2711_rx_pat_chk`:
  - Holds `idx`, the expected-word compare, `bad`, and the counters including saturation and clear.
  - Driven by a `data_en`/`first`/`last`/`abort` strobe set from the FSM.

## Test plan
- **Lock and frame:** 4 COMMA, SOFW, then 32 DATA words 0x0000..0x1F1F.
  - `o_sync`=1 after lock.
  - 32 `o_valid` words: `o_sof` on 0x0000, `o_eof` on 0x1F1F.
  - `o_frame_cnt`=1, `o_err_cnt`=0.
- **Mismatch:** same frame with word 5 = 0x0506.
  - `o_err_cnt`=1.
  - `o_frame_err` pulse coincident with `o_eof`.
  - `o_frame_cnt` unchanged.
- **Abort:** SOFW, 10 DATA, COMMA.
  - No `o_eof`.
  - `o_frame_err` pulse 2 cycles after the COMMA.
  - `o_err_cnt`+1; state returns to SYNC.
- **Sync loss:** in SYNC, send 4 words rk=01 → `o_sync`=0. Three bad words then one COMMA → sync retained.
- **Counter clear and saturation:**
  - Force `o_err_cnt` to 0xFFFF, then a mismatch → stays 0xFFFF.
  - `i_clr_cnt` in the same cycle as a good EOF → both counters 0.
- **Async reset mid-frame at word 12:** all outputs 0 without a clock edge. Frame not counted.

Source files
------------

// File: rtl/tlk2711_pkg.sv
// Shared TLK2711 link definitions: 8b/10b control characters, word classes and rx states.
// Used by both the receive checker and the transmit frame generator.
package tlk2711_pkg;

    localparam logic [7:0] K28_5 = 8'hBC;
    localparam logic [7:0] D5_6  = 8'hC5;
    localparam logic [7:0] D11_5 = 8'hAB;

    typedef enum logic [1:0] {
        WC_COMMA,
        WC_SOFW,
        WC_DATA,
        WC_BAD
    } word_class_e;

    typedef enum logic [1:0] {
        HUNT,
        SYNC,
        FRAME
    } rx_state_e;

    // One received parallel word with its per-byte K flags {msb, lsb}
    typedef struct packed {
        logic [1:0]  rk;
        logic [15:0] data;
    } rx_word_t;

    function automatic word_class_e classify(input rx_word_t w);
        if (w.rk == 2'b10 && w.data == {K28_5, D5_6}) begin
            return WC_COMMA;
        end
        if (w.rk == 2'b10 && w.data == {K28_5, D11_5}) begin
            return WC_SOFW;
        end
        if (w.rk == 2'b00) begin
            return WC_DATA;
        end
        return WC_BAD;
    endfunction

    // Test pattern: both bytes carry the low five bits of the word index
    function automatic logic [15:0] pattern_word(input logic [7:0] idx);
        return {3'b000, idx[4:0], 3'b000, idx[4:0]};
    endfunction

endpackage

// File: rtl/tlk2711_rx_pat_chk.sv
// Payload pattern checker: word index, expected-word compare, per-frame error flag,
// registered payload outputs and the frame / error statistics counters.
module tlk2711_rx_pat_chk
    import tlk2711_pkg::*;
#(
    parameter int unsigned FRAME_LEN = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        data_en,
    input  logic        first,
    input  logic        last,
    input  logic        abort,
    input  logic        clr,
    input  logic [15:0] rx_data,
    output logic        at_last_c,
    output logic [15:0] pay_data,
    output logic        pay_valid,
    output logic        pay_sof,
    output logic        pay_eof,
    output logic        frame_err,
    output logic [31:0] frame_cnt,
    output logic [15:0] err_cnt
);

    localparam logic [7:0] LAST_IDX = 8'(FRAME_LEN - 1);

    logic [7:0] idx;
    logic       bad;
    logic       mismatch_c;
    logic       err_inc_c;
    logic       good_eof_c;

    assign at_last_c  = (idx == LAST_IDX);
    assign mismatch_c = data_en && (rx_data != pattern_word(idx));
    assign err_inc_c  = mismatch_c || abort;
    assign good_eof_c = last && !bad && !mismatch_c;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx       <= '0;
            bad       <= 1'b0;
            pay_data  <= '0;
            pay_valid <= 1'b0;
            pay_sof   <= 1'b0;
            pay_eof   <= 1'b0;
            frame_err <= 1'b0;
            frame_cnt <= '0;
            err_cnt   <= '0;
        end else begin
            pay_valid <= data_en;
            pay_sof   <= data_en && (idx == 8'd0);
            pay_eof   <= last;
            frame_err <= abort || (last && (bad || mismatch_c));

            if (data_en) begin
                pay_data <= rx_data;
                idx      <= idx + 8'd1;
                if (mismatch_c) begin
                    bad <= 1'b1;
                end
            end
            if (first) begin
                idx <= '0;
                bad <= 1'b0;
            end

            // Clear takes priority over a same-cycle increment
            if (clr) begin
                frame_cnt <= '0;
                err_cnt   <= '0;
            end else begin
                if (good_eof_c) begin
                    frame_cnt <= frame_cnt + 32'd1;
                end
                if (err_inc_c && err_cnt != 16'hFFFF) begin
                    err_cnt <= err_cnt + 16'd1;
                end
            end
        end
    end

endmodule

// File: rtl/tlk2711_rx_checker.sv
// TLK2711 receive decoder: registers the pins, acquires comma sync, tracks SOF-delimited
// frames and hands payload words to the pattern checker.
module tlk2711_rx_checker
    import tlk2711_pkg::*;
#(
    parameter int unsigned FRAME_LEN = 32,
    parameter int unsigned LOCK_CNT  = 4,
    parameter int unsigned LOSS_CNT  = 4
) (
    input  logic        rx_clk,
    input  logic        rst,
    input  logic [15:0] i_rxd,
    input  logic        i_rkmsb,
    input  logic        i_rklsb,
    input  logic        i_clr_cnt,
    output logic        o_sync,
    output logic [15:0] o_data,
    output logic        o_valid,
    output logic        o_sof,
    output logic        o_eof,
    output logic        o_frame_err,
    output logic [31:0] o_frame_cnt,
    output logic [15:0] o_err_cnt
);

    localparam int unsigned LOCK_W = $clog2(LOCK_CNT + 1);
    localparam int unsigned LOSS_W = $clog2(LOSS_CNT + 1);

    rx_word_t    word_q;
    word_class_e wclass;
    rx_state_e   state_q, state_d;
    logic [LOCK_W-1:0] lock_q, lock_d, lock_nxt;
    logic [LOSS_W-1:0] loss_q, loss_d, loss_nxt;
    logic        sync_d;
    logic        data_en, first, last, abort;
    logic        at_last_c;

    // Single input register stage; all decoding works from this copy
    always_ff @(posedge rx_clk or posedge rst) begin
        if (rst) begin
            word_q <= '0;
        end else begin
            word_q <= '{rk: {i_rkmsb, i_rklsb}, data: i_rxd};
        end
    end

    assign wclass   = classify(word_q);
    assign lock_nxt = lock_q + LOCK_W'(1);
    assign loss_nxt = loss_q + LOSS_W'(1);

    always_ff @(posedge rx_clk or posedge rst) begin
        if (rst) begin
            state_q <= HUNT;
            lock_q  <= '0;
            loss_q  <= '0;
            o_sync  <= 1'b0;
        end else begin
            state_q <= state_d;
            lock_q  <= lock_d;
            loss_q  <= loss_d;
            o_sync  <= sync_d;
        end
    end

    always_comb begin
        state_d = state_q;
        lock_d  = lock_q;
        loss_d  = loss_q;
        sync_d  = o_sync;
        data_en = 1'b0;
        first   = 1'b0;
        last    = 1'b0;
        abort   = 1'b0;
        case (state_q)
            HUNT: begin
                if (wclass == WC_COMMA) begin
                    if (lock_nxt == LOCK_W'(LOCK_CNT)) begin
                        state_d = SYNC;
                        sync_d  = 1'b1;
                        lock_d  = '0;
                        loss_d  = '0;
                    end else begin
                        lock_d = lock_nxt;
                    end
                end else begin
                    lock_d = '0;
                end
            end
            SYNC: begin
                case (wclass)
                    WC_COMMA: loss_d = '0;
                    WC_SOFW: begin
                        state_d = FRAME;
                        first   = 1'b1;
                        loss_d  = '0;
                    end
                    default: begin
                        if (loss_nxt == LOSS_W'(LOSS_CNT)) begin
                            state_d = HUNT;
                            sync_d  = 1'b0;
                            lock_d  = '0;
                            loss_d  = '0;
                        end else begin
                            loss_d = loss_nxt;
                        end
                    end
                endcase
            end
            FRAME: begin
                // Any K word inside a frame aborts it; SOFW immediately starts a new one
                case (wclass)
                    WC_DATA: begin
                        data_en = 1'b1;
                        last    = at_last_c;
                        if (at_last_c) begin
                            state_d = SYNC;
                        end
                    end
                    WC_SOFW: begin
                        abort = 1'b1;
                        first = 1'b1;
                    end
                    WC_COMMA: begin
                        abort   = 1'b1;
                        state_d = SYNC;
                        loss_d  = '0;
                    end
                    default: begin
                        abort   = 1'b1;
                        state_d = SYNC;
                        loss_d  = LOSS_W'(1);
                    end
                endcase
            end
            default: state_d = HUNT;
        endcase
    end

    tlk2711_rx_pat_chk #(
        .FRAME_LEN(FRAME_LEN)
    ) u_pat_chk (
        .clk      (rx_clk),
        .rst      (rst),
        .data_en  (data_en),
        .first    (first),
        .last     (last),
        .abort    (abort),
        .clr      (i_clr_cnt),
        .rx_data  (word_q.data),
        .at_last_c(at_last_c),
        .pay_data (o_data),
        .pay_valid(o_valid),
        .pay_sof  (o_sof),
        .pay_eof  (o_eof),
        .frame_err(o_frame_err),
        .frame_cnt(o_frame_cnt),
        .err_cnt  (o_err_cnt)
    );

endmodule

// File: tb/tb_tlk2711_rx_checker.sv
// Scoreboard bench for tlk2711_rx_checker: a word-level link model predicts every
// payload word / frame-error event and o_sync; a negedge monitor checks the DUT.
module tb_tlk2711_rx_checker;

    localparam int FL = 32;
    localparam int LK = 4;
    localparam int LS = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] rxd = '0;
    logic        rkmsb = 1'b0;
    logic        rklsb = 1'b0;
    logic        clr = 1'b0;
    logic        o_sync;
    logic [15:0] o_data;
    logic        o_valid;
    logic        o_sof;
    logic        o_eof;
    logic        o_frame_err;
    logic [31:0] o_frame_cnt;
    logic [15:0] o_err_cnt;

    always #5 clk = ~clk;

    tlk2711_rx_checker #(
        .FRAME_LEN(FL),
        .LOCK_CNT (LK),
        .LOSS_CNT (LS)
    ) dut (
        .rx_clk     (clk),
        .rst        (rst),
        .i_rxd      (rxd),
        .i_rkmsb    (rkmsb),
        .i_rklsb    (rklsb),
        .i_clr_cnt  (clr),
        .o_sync     (o_sync),
        .o_data     (o_data),
        .o_valid    (o_valid),
        .o_sof      (o_sof),
        .o_eof      (o_eof),
        .o_frame_err(o_frame_err),
        .o_frame_cnt(o_frame_cnt),
        .o_err_cnt  (o_err_cnt)
    );

    typedef struct {
        bit          valid;
        logic [15:0] data;
        bit          sof;
        bit          eof;
        bit          ferr;
        logic [31:0] fcnt;
        logic [15:0] ecnt;
        bit          sync;
        int          cyc;
    } ev_t;

    ev_t exp_q[$];
    ev_t mon_e;
    int  checks = 0;
    int  errors = 0;
    int  cyc = 0;

    // Link model: 0 = hunting, 1 = in sync between frames, 2 = inside a frame
    int          m_mode, m_lock, m_loss, m_idx, m_ecnt;
    bit          m_bad, m_sync, prev_clr;
    logic [31:0] m_fcnt;
    bit          h0, h1, h2;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_lock = 0; m_loss = 0; m_idx = 0; m_ecnt = 0;
        m_bad = 0; m_sync = 0; m_fcnt = '0; prev_clr = 0;
        h0 = 0; h1 = 0; h2 = 0;
        exp_q.delete();
    endtask

    // Apply one word (and the clear that accompanies its processing) to the model
    task automatic model_word(input bit [1:0] rk, input logic [15:0] d, input bit c);
        bit          is_comma, is_sofw, is_data, ev, fr_inc, er_inc;
        logic [15:0] want;
        ev_t         e;
        is_comma = (rk == 2'b10) && (d == 16'hBCC5);
        is_sofw  = (rk == 2'b10) && (d == 16'hBCAB);
        is_data  = (rk == 2'b00);
        ev = 0; fr_inc = 0; er_inc = 0;
        e = '{default: 0};
        e.cyc = cyc + 2;
        if (m_mode == 0) begin
            if (is_comma) begin
                m_lock++;
                if (m_lock == LK) begin
                    m_mode = 1; m_sync = 1; m_lock = 0; m_loss = 0;
                end
            end else begin
                m_lock = 0;
            end
        end else if (m_mode == 1) begin
            if (is_comma) begin
                m_loss = 0;
            end else if (is_sofw) begin
                m_mode = 2; m_idx = 0; m_bad = 0; m_loss = 0;
            end else begin
                m_loss++;
                if (m_loss == LS) begin
                    m_mode = 0; m_sync = 0; m_lock = 0; m_loss = 0;
                end
            end
        end else if (is_data) begin
            want    = {8'(m_idx % 32), 8'(m_idx % 32)};
            ev      = 1;
            e.valid = 1;
            e.data  = d;
            e.sof   = (m_idx == 0);
            e.eof   = (m_idx == FL - 1);
            if (d !== want) begin
                m_bad = 1; er_inc = 1;
            end
            m_idx++;
            if (m_idx == FL) begin
                m_mode = 1;
                if (m_bad) e.ferr = 1;
                else fr_inc = 1;
            end
        end else begin
            ev = 1; e.ferr = 1; er_inc = 1;
            if (is_sofw) begin
                m_idx = 0; m_bad = 0;
            end else if (is_comma) begin
                m_mode = 1; m_loss = 0;
            end else begin
                m_mode = 1; m_loss = 1;
            end
        end
        if (c) begin
            m_fcnt = '0; m_ecnt = 0;
        end else begin
            if (fr_inc) m_fcnt = m_fcnt + 32'd1;
            if (er_inc && m_ecnt < 65535) m_ecnt++;
        end
        e.fcnt = m_fcnt;
        e.ecnt = 16'(m_ecnt);
        e.sync = m_sync;
        if (ev) exp_q.push_back(e);
    endtask

    // Drive one word; its clear flag goes out with the following word
    task automatic send(input bit [1:0] rk, input logic [15:0] d, input bit c);
        @(posedge clk);
        #1;
        rxd = d;
        {rkmsb, rklsb} = rk;
        clr = prev_clr;
        prev_clr = c;
        model_word(rk, d, c);
        h2 = h1; h1 = h0; h0 = m_sync;
        chk("sync_track", 32'(o_sync), 32'(h2));
    endtask

    task automatic send_comma(input int n);
        for (int i = 0; i < n; i++) send(2'b10, 16'hBCC5, 1'b0);
    endtask

    task automatic send_frame(input int bad_at, input logic [15:0] bad_val, input bit clr_last,
                              input int nwords);
        logic [15:0] w;
        send(2'b10, 16'hBCAB, 1'b0);
        for (int i = 0; i < nwords; i++) begin
            w = {8'(i % 32), 8'(i % 32)};
            if (i == bad_at) w = bad_val;
            send(2'b00, w, clr_last && (i == FL - 1));
        end
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        #1;
        chk("rst_sync", 32'(o_sync), 32'd0);
        chk("rst_data", 32'(o_data), 32'd0);
        chk("rst_valid", 32'(o_valid), 32'd0);
        chk("rst_sof", 32'(o_sof), 32'd0);
        chk("rst_eof", 32'(o_eof), 32'd0);
        chk("rst_frame_err", 32'(o_frame_err), 32'd0);
        chk("rst_frame_cnt", o_frame_cnt, 32'd0);
        chk("rst_err_cnt", 32'(o_err_cnt), 32'd0);
        rxd = '0; rkmsb = 1'b0; rklsb = 1'b0; clr = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Monitor: pops one expected event for every DUT payload word or frame-error pulse
    always @(negedge clk) begin
        if (!rst) begin
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                checks++;
                errors++;
                $display("FAIL missed_event at cycle %0d expected at %0d", cyc, exp_q[0].cyc);
                exp_q.delete(0);
            end
            if (o_valid || o_frame_err) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output cycle %0d valid %0b data %0h ferr %0b",
                             cyc, o_valid, o_data, o_frame_err);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("ev_cycle", 32'(cyc), 32'(mon_e.cyc));
                    chk("ev_valid", 32'(o_valid), 32'(mon_e.valid));
                    if (mon_e.valid) chk("ev_data", 32'(o_data), 32'(mon_e.data));
                    chk("ev_sof", 32'(o_sof), 32'(mon_e.sof));
                    chk("ev_eof", 32'(o_eof), 32'(mon_e.eof));
                    chk("ev_frame_err", 32'(o_frame_err), 32'(mon_e.ferr));
                    chk("ev_frame_cnt", o_frame_cnt, mon_e.fcnt);
                    chk("ev_err_cnt", 32'(o_err_cnt), 32'(mon_e.ecnt));
                    chk("ev_sync", 32'(o_sync), 32'(mon_e.sync));
                end
            end
        end
    end

    initial begin
        model_reset();
        #2;
        apply_reset();

        // Lock and one clean frame
        send_comma(LK);
        send_frame(-1, 16'h0, 1'b0, FL);
        send_comma(3);
        chk("lock_sync", 32'(o_sync), 32'd1);
        chk("good_frame_cnt", o_frame_cnt, 32'd1);
        chk("good_err_cnt", 32'(o_err_cnt), 32'd0);

        // Mismatch on word 5
        send_frame(5, 16'h0506, 1'b0, FL);
        send_comma(3);
        chk("mismatch_frame_cnt", o_frame_cnt, 32'd1);
        chk("mismatch_err_cnt", 32'(o_err_cnt), 32'd1);

        // Abort after 10 data words
        send_frame(-1, 16'h0, 1'b0, 10);
        send_comma(3);
        chk("abort_err_cnt", 32'(o_err_cnt), 32'd2);
        chk("abort_frame_cnt", o_frame_cnt, 32'd1);
        chk("abort_sync", 32'(o_sync), 32'd1);

        // Sync loss, relock, and a run of bad words that stops short of loss
        for (int i = 0; i < LS; i++) send(2'b01, 16'h1234, 1'b0);
        send_comma(2);
        chk("loss_sync", 32'(o_sync), 32'd0);
        send_comma(LK);
        for (int i = 0; i < LS - 1; i++) send(2'b01, 16'h5678, 1'b0);
        send_comma(3);
        chk("retain_sync", 32'(o_sync), 32'd1);

        // Randomized traffic
        for (int it = 0; it < 100; it++) begin
            int unsigned kind;
            bit c;
            kind = $urandom_range(0, 5);
            c = ($urandom_range(0, 15) == 0);
            case (kind)
                0: send_frame(-1, 16'h0, c, FL);
                1: send_frame(int'($urandom_range(0, FL - 1)), 16'($urandom), c, FL);
                2: begin
                    send_frame(-1, 16'h0, 1'b0, int'($urandom_range(1, FL - 1)));
                    case ($urandom_range(0, 3))
                        0: send(2'b10, 16'hBCC5, c);
                        1: send(2'b10, 16'hBCAB, c);
                        2: send(2'b01, 16'($urandom), c);
                        default: send(2'b11, 16'($urandom), c);
                    endcase
                end
                3: for (int i = 0; i < int'($urandom_range(1, 5)); i++)
                       send(2'($urandom_range(1, 3)), 16'($urandom), 1'b0);
                4: send_comma(int'($urandom_range(1, 6)));
                default: for (int i = 0; i < int'($urandom_range(1, 4)); i++)
                       send(2'($urandom_range(0, 3)), 16'($urandom), c);
            endcase
        end

        // Drive the error counter to saturation with back-to-back SOF aborts
        send_comma(LK + 1);
        send(2'b10, 16'hBCAB, 1'b0);
        while (m_ecnt < 65535) send(2'b10, 16'hBCAB, 1'b0);
        send(2'b10, 16'hBCAB, 1'b0);
        for (int i = 0; i < FL; i++)
            send(2'b00, (i == 5) ? 16'h0506 : {8'(i), 8'(i)}, 1'b0);
        send_comma(3);
        chk("sat_err_cnt", 32'(o_err_cnt), 32'h0000FFFF);

        // Clear in the same cycle as a good EOF
        send_frame(-1, 16'h0, 1'b1, FL);
        send_comma(3);
        chk("clr_frame_cnt", o_frame_cnt, 32'd0);
        chk("clr_err_cnt", 32'(o_err_cnt), 32'd0);

        // Async reset in the middle of a frame at word 12
        send_comma(LK);
        send_frame(-1, 16'h0, 1'b0, 1);
        send_frame(-1, 16'h0, 1'b0, FL);
        send_comma(1);
        send_frame(-1, 16'h0, 1'b0, 13);
        apply_reset();
        send_comma(LK);
        send_frame(-1, 16'h0, 1'b0, FL);
        send_comma(4);
        chk("post_reset_frame_cnt", o_frame_cnt, 32'd1);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        #1;
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        chk("final_frame_cnt", o_frame_cnt, m_fcnt);
        chk("final_err_cnt", 32'(o_err_cnt), 32'(m_ecnt));
        chk("final_sync", 32'(o_sync), 32'(m_sync));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
